jtoutrun_ram_arb: RTL
=====================

// Module: jtoutrun_ram_arb
// PURPOSE
// Shares SDRAM bank 0 between the main 68000 work RAM and the sub 68000 work RAM on OutRun.
// Each CPU presents a chip-select plus address/data, and the block serialises their accesses
// onto the single bank-0 read/write port. It returns data and ok per requester.
// It sits between the CPU decoders and the SDRAM controller, replacing direct per-CPU bank slots.
// PARAMETERS
// AW        18         word-address width of each requester
// M_OFFSET  22'h00000  bank-0 word offset added to the main RAM address
// S_OFFSET  22'h10000  bank-0 word offset added to the sub RAM address
// PORTS
// clk       in   1    system clock; everything is sampled on its rising edge
// rst       in   1    synchronous, active-high reset
// m_cs      in   1    main RAM request; held high until m_ok
// m_addr    in   AW   main word address
// m_rnw     in   1    1=read, 0=write
// m_dsn     in   2    byte strobes, active low ([1]=upper)
// m_din     in   16   main write data
// m_dout    out  16   main read data
// m_ok      out  1    main access complete
// s_cs, s_addr, s_rnw, s_dsn, s_din, s_dout, s_ok   sub-CPU equivalents, same widths
// ba_addr   out  22   bank-0 word address
// ba_rd     out  1    bank-0 read request
// ba_wr     out  1    bank-0 write request
// ba_din    out  16   bank-0 write data
// ba_din_m  out  2    bank-0 write mask (= dsn of the granted requester)
// ba_ack    in   1    controller accepted the request (1-cycle pulse)
// ba_rdy    in   1    transfer finished; data_read valid on reads (1-cycle pulse)
// data_read in   16   SDRAM read data
// BEHAVIOUR
// - Reset values: every output is 0 (m_dout, s_dout, ba_* and both ok flags).
//   Reset also sets the state to IDLE, clears both completion records and sets last=SUB.
// - State machine:
//   - IDLE -> REQ: entered when any cs is high and that requester's access is not already complete.
//   - On that transition, latch the grant (g), the address, rnw, dsn and din of the winner.
//   - REQ: ba_rd=g.rnw, ba_wr=~g.rnw, ba_addr=OFFSET_g+{zero-ext addr} (mod 2^22).
//     On ba_ack, drop ba_rd/ba_wr in the next cycle -> WAIT.
//   - WAIT: on ba_rdy, capture data_read into g's dout on reads (dout is unchanged on writes),
//     record g's completed address, set last=g -> IDLE.
// - Arbitration happens only in IDLE:
//   - only one requester pending: grant it;
//   - both pending: grant the one != last (round-robin);
//   - after reset with both pending, main wins.
// - Completion: x_ok=1 while x_cs=1, x_addr equals the recorded address and the record is valid.
//   x_ok goes to 0 the cycle after x_cs falls or x_addr changes, and the record is cleared then.
//   A held cs never issues a second SDRAM access.
// - Latency: best case, ba_rd/ba_wr is high 1 cycle after cs, and ok is high 1 cycle after ba_rdy.
// - Requests are never aborted once issued.
//   If x_cs drops during REQ/WAIT, the SDRAM access still completes, but no record is stored
//   and x_ok stays 0.
// - The requester that was not granted keeps waiting.
//   It is granted in the IDLE cycle after the current access ends (one idle cycle minimum).
// - ba_ack and ba_rdy arriving in the same cycle: treat the ack as taken and go straight to IDLE.
// - ba_ack or ba_rdy arriving while in IDLE is ignored.
// - Reset mid-access: state returns to IDLE immediately and ba_rd/ba_wr drop the next cycle.
//   Any later ba_rdy is ignored.
// - ba_din and ba_din_m stay stable from REQ entry until IDLE. A write always sets ok; no data is returned.
// TESTING
// 1. Main read only: m_cs=1, m_addr=18'h00123; model acks after 3 cycles, rdy after 6 with
//    data 16'hBEEF -> ba_addr=22'h00123, ba_rd one pulse train, m_dout=BEEF, m_ok held until m_cs=0.
// 2. Sub write: s_cs=1, s_rnw=0, s_addr=0, s_dsn=2'b01, s_din=16'h1234 -> ba_wr=1,
//    ba_addr=22'h10000, ba_din_m=01, ba_din=1234, s_ok=1 after rdy, s_dout unchanged.
// 3. Simultaneous m_cs/s_cs right after reset -> main is served first, then sub.
//    Repeat the pair -> main again (last=SUB). Sub held continuously never starves past one main access.
// 4. m_cs dropped during WAIT -> access completes, m_ok never rises.
//    Re-assert same address -> a new SDRAM read is issued.
// 5. Address change with cs held high: m_addr 5->6 after m_ok -> m_ok falls next cycle
//    and a second read is issued to 22'h00006.
// 6. rst pulsed during WAIT -> all outputs are 0 next cycle, a late ba_rdy is ignored,
//    and a fresh request completes normally.

Source files
------------

// File: rtl/jtoutrun_ram_arb.sv
// rtl/jtoutrun_ram_arb.sv - SDRAM bank-0 arbiter for the OutRun main and sub 68000 work RAMs
//
// Purpose: two CPU work-RAM requesters (main, sub) share one bank-0 read/write port.
// Accesses are serialised, round-robin when both are pending, and each requester gets its
// own read data and ok flag back.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m_cs_i .. m_din_i            main request: chip select, word address, rnw, byte strobes (active low), write data
//   m_dout_o, m_ok_o             main read data, access complete
//   s_*                          sub-CPU equivalents
//   ba_addr_o, ba_rd_o, ba_wr_o  bank-0 word address, read / write request
//   ba_din_o, ba_din_m_o         bank-0 write data and write mask
//   ba_ack_i, ba_rdy_i           controller accepted request / transfer finished (1-cycle pulses)
//   data_read_i                  SDRAM read data, valid with ba_rdy_i on reads
module jtoutrun_ram_arb #(
  parameter int          AW       = 18,
  parameter logic [21:0] M_OFFSET = 22'h00000,
  parameter logic [21:0] S_OFFSET = 22'h10000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m_cs_i,
  input  logic [AW-1:0] m_addr_i,
  input  logic          m_rnw_i,
  input  logic [1:0]    m_dsn_i,
  input  logic [15:0]   m_din_i,
  output logic [15:0]   m_dout_o,
  output logic          m_ok_o,
  input  logic          s_cs_i,
  input  logic [AW-1:0] s_addr_i,
  input  logic          s_rnw_i,
  input  logic [1:0]    s_dsn_i,
  input  logic [15:0]   s_din_i,
  output logic [15:0]   s_dout_o,
  output logic          s_ok_o,
  output logic [21:0]   ba_addr_o,
  output logic          ba_rd_o,
  output logic          ba_wr_o,
  output logic [15:0]   ba_din_o,
  output logic [1:0]    ba_din_m_o,
  input  logic          ba_ack_i,
  input  logic          ba_rdy_i,
  input  logic [15:0]   data_read_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic       SEL_M   = 1'b0;
  localparam logic       SEL_S   = 1'b1;

  logic [1:0]    st_q, st_d;
  logic          g_q, g_d;
  logic          last_q, last_d;
  logic          rnw_q, rnw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [21:0]   ba_addr_q, ba_addr_d;
  logic          ba_rd_q, ba_rd_d;
  logic          ba_wr_q, ba_wr_d;
  logic [15:0]   ba_din_q, ba_din_d;
  logic [1:0]    ba_din_m_q, ba_din_m_d;
  logic [15:0]   m_dout_q, m_dout_d;
  logic [15:0]   s_dout_q, s_dout_d;
  logic          m_rec_v_q, m_rec_v_d;
  logic          s_rec_v_q, s_rec_v_d;
  logic [AW-1:0] m_rec_a_q, m_rec_a_d;
  logic [AW-1:0] s_rec_a_q, s_rec_a_d;

  logic m_pend, s_pend, grant_s, finish, g_keep;

  // A requester is pending while it holds cs and its current address has no completion record.
  assign m_pend  = m_cs_i && !(m_rec_v_q && (m_addr_i == m_rec_a_q));
  assign s_pend  = s_cs_i && !(s_rec_v_q && (s_addr_i == s_rec_a_q));
  assign grant_s = s_pend && (!m_pend || (last_q == SEL_M));

  // ack and rdy in the same REQ cycle complete the access directly.
  assign finish  = ba_rdy_i && ((st_q == ST_WAIT) || ((st_q == ST_REQ) && ba_ack_i));

  // Only record completion if the granted CPU still wants the same word.
  assign g_keep  = (g_q == SEL_S) ? (s_cs_i && (s_addr_i == addr_q))
                                  : (m_cs_i && (m_addr_i == addr_q));

  always_comb begin
    st_d       = st_q;
    g_d        = g_q;
    last_d     = last_q;
    rnw_d      = rnw_q;
    addr_d     = addr_q;
    ba_addr_d  = ba_addr_q;
    ba_rd_d    = ba_rd_q;
    ba_wr_d    = ba_wr_q;
    ba_din_d   = ba_din_q;
    ba_din_m_d = ba_din_m_q;
    m_dout_d   = m_dout_q;
    s_dout_d   = s_dout_q;
    m_rec_v_d  = m_rec_v_q;
    s_rec_v_d  = s_rec_v_q;
    m_rec_a_d  = m_rec_a_q;
    s_rec_a_d  = s_rec_a_q;

    // Drop a record as soon as its owner releases cs or moves to another address.
    if (m_rec_v_q && !(m_cs_i && (m_addr_i == m_rec_a_q))) m_rec_v_d = 1'b0;
    if (s_rec_v_q && !(s_cs_i && (s_addr_i == s_rec_a_q))) s_rec_v_d = 1'b0;

    case (st_q)
      ST_IDLE: begin
        if (m_pend || s_pend) begin
          st_d = ST_REQ;
          g_d  = grant_s;
          if (grant_s) begin
            addr_d     = s_addr_i;
            rnw_d      = s_rnw_i;
            ba_addr_d  = S_OFFSET + 22'(s_addr_i);
            ba_din_d   = s_din_i;
            ba_din_m_d = s_dsn_i;
            ba_rd_d    = s_rnw_i;
            ba_wr_d    = ~s_rnw_i;
          end else begin
            addr_d     = m_addr_i;
            rnw_d      = m_rnw_i;
            ba_addr_d  = M_OFFSET + 22'(m_addr_i);
            ba_din_d   = m_din_i;
            ba_din_m_d = m_dsn_i;
            ba_rd_d    = m_rnw_i;
            ba_wr_d    = ~m_rnw_i;
          end
        end
      end
      ST_REQ: begin
        if (ba_ack_i) begin
          ba_rd_d = 1'b0;
          ba_wr_d = 1'b0;
          st_d    = ba_rdy_i ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ba_rdy_i) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase

    if (finish) begin
      last_d = g_q;
      if (g_q == SEL_S) begin
        if (rnw_q) s_dout_d = data_read_i;
        if (g_keep) begin
          s_rec_v_d = 1'b1;
          s_rec_a_d = addr_q;
        end
      end else begin
        if (rnw_q) m_dout_d = data_read_i;
        if (g_keep) begin
          m_rec_v_d = 1'b1;
          m_rec_a_d = addr_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q       <= ST_IDLE;
      g_q        <= SEL_M;
      last_q     <= SEL_S;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      ba_addr_q  <= '0;
      ba_rd_q    <= 1'b0;
      ba_wr_q    <= 1'b0;
      ba_din_q   <= '0;
      ba_din_m_q <= '0;
      m_dout_q   <= '0;
      s_dout_q   <= '0;
      m_rec_v_q  <= 1'b0;
      s_rec_v_q  <= 1'b0;
      m_rec_a_q  <= '0;
      s_rec_a_q  <= '0;
    end else begin
      st_q       <= st_d;
      g_q        <= g_d;
      last_q     <= last_d;
      rnw_q      <= rnw_d;
      addr_q     <= addr_d;
      ba_addr_q  <= ba_addr_d;
      ba_rd_q    <= ba_rd_d;
      ba_wr_q    <= ba_wr_d;
      ba_din_q   <= ba_din_d;
      ba_din_m_q <= ba_din_m_d;
      m_dout_q   <= m_dout_d;
      s_dout_q   <= s_dout_d;
      m_rec_v_q  <= m_rec_v_d;
      s_rec_v_q  <= s_rec_v_d;
      m_rec_a_q  <= m_rec_a_d;
      s_rec_a_q  <= s_rec_a_d;
    end
  end

  assign m_dout_o   = m_dout_q;
  assign s_dout_o   = s_dout_q;
  assign m_ok_o     = m_rec_v_q;
  assign s_ok_o     = s_rec_v_q;
  assign ba_addr_o  = ba_addr_q;
  assign ba_rd_o    = ba_rd_q;
  assign ba_wr_o    = ba_wr_q;
  assign ba_din_o   = ba_din_q;
  assign ba_din_m_o = ba_din_m_q;

endmodule
